// File: rtl/wormhole_switch_allocator.sv
// wormhole_switch_allocator
//   Two-stage separable switch allocator for one NoC router.
//   Stage 1 picks one eligible VC per input port (round-robin from vc_ptr).
//   Stage 2 picks one input per output port (round-robin from ip_ptr), or
//   only the lock owner while the output is inside a wormhole packet.
//   Grants and crossbar selects are registered: inputs sampled at edge t
//   appear on the outputs right after edge t.
// Parameters
//   PORT_CNT  router ports (in = out), >= 2
//   VC_NUM    virtual channels per input port
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   request_in      [port][vc]       VC holds a flit wanting the switch
//   out_port_in     [port][vc][OPW]  routed output of that flit
//   tail_in         [port][vc]       flit is a tail (or single-flit packet)
//   out_ready_in    [port]           output has downstream credit
//   grant_o         [port][vc]       registered grant, <=1 per input
//   xbar_valid_o    [port]           registered: output carries a flit
//   xbar_sel_o      [port][IPW]      registered: input driving the output

// Round-robin pick: first set bit of i_req at or after i_ptr, wrapping
// modulo N (N need not be a power of two).
module wsa_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic         o_vld,
  output logic [W-1:0] o_idx
);
  logic [W:0] w_sum;

  // Scan from the farthest offset down so the closest requester wins last.
  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    w_sum = '0;
    for (int k = N-1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (W+1)'(k);
      if (w_sum >= (W+1)'(N)) w_sum = w_sum - (W+1)'(N);
      if (i_req[w_sum[W-1:0]]) begin
        o_vld = 1'b1;
        o_idx = w_sum[W-1:0];
      end
    end
  end
endmodule

module wormhole_switch_allocator #(
  parameter  int PORT_CNT = 5,
  parameter  int VC_NUM   = 4,
  localparam int OPW      = $clog2(PORT_CNT),
  localparam int IPW      = $clog2(PORT_CNT)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [PORT_CNT-1:0][VC_NUM-1:0]          request_in,
  input  logic [PORT_CNT-1:0][VC_NUM-1:0][OPW-1:0] out_port_in,
  input  logic [PORT_CNT-1:0][VC_NUM-1:0]          tail_in,
  input  logic [PORT_CNT-1:0]                      out_ready_in,
  output logic [PORT_CNT-1:0][VC_NUM-1:0]          grant_o,
  output logic [PORT_CNT-1:0]                      xbar_valid_o,
  output logic [PORT_CNT-1:0][IPW-1:0]             xbar_sel_o
);
  localparam int VCW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  // state
  logic [PORT_CNT-1:0][VCW-1:0]         r_vc_ptr;
  logic [PORT_CNT-1:0][IPW-1:0]         r_ip_ptr;
  logic [PORT_CNT-1:0]                  r_lock;
  logic [PORT_CNT-1:0][IPW-1:0]         r_own_p;
  logic [PORT_CNT-1:0][VCW-1:0]         r_own_v;
  logic [PORT_CNT-1:0][VC_NUM-1:0]      r_grant;
  logic [PORT_CNT-1:0]                  r_xv;
  logic [PORT_CNT-1:0][IPW-1:0]         r_xs;

  // stage 1 (per input)
  logic [PORT_CNT-1:0]                  w_s1_vld;
  logic [PORT_CNT-1:0][VCW-1:0]         w_s1_vc;
  logic [PORT_CNT-1:0][OPW-1:0]         w_s1_op;
  logic [PORT_CNT-1:0]                  w_s1_tail;
  logic [PORT_CNT-1:0][VCW-1:0]         w_nxt_vc;
  logic [PORT_CNT-1:0]                  w_in_won;

  // stage 2 (per output)
  logic [PORT_CNT-1:0]                  w_gnt_vld;
  logic [PORT_CNT-1:0][IPW-1:0]         w_gnt_ip;
  logic [PORT_CNT-1:0][VCW-1:0]         w_gnt_vc;
  logic [PORT_CNT-1:0]                  w_gnt_tail;
  logic [PORT_CNT-1:0][IPW-1:0]         w_nxt_ip;

  logic [PORT_CNT-1:0][VC_NUM-1:0]      w_grant;

  for (genvar p = 0; p < PORT_CNT; p++) begin : g_in
    logic [VC_NUM-1:0] w_elig;

    // A VC may bid only for an in-range, ready output that is either free
    // or already locked to this very VC.
    always_comb begin
      w_elig = '0;
      for (int v = 0; v < VC_NUM; v++) begin
        if (request_in[p][v] &&
            ({1'b0, out_port_in[p][v]} < (OPW+1)'(PORT_CNT))) begin
          w_elig[v] = out_ready_in[out_port_in[p][v]] &&
                      (!r_lock[out_port_in[p][v]] ||
                       ((r_own_p[out_port_in[p][v]] == IPW'(p)) &&
                        (r_own_v[out_port_in[p][v]] == VCW'(v))));
        end
      end
    end

    wsa_rr_pick #(.N(VC_NUM), .W(VCW)) u_vc_rr (
      .i_req (w_elig),
      .i_ptr (r_vc_ptr[p]),
      .o_vld (w_s1_vld[p]),
      .o_idx (w_s1_vc[p])
    );

    assign w_s1_op[p]   = out_port_in[p][w_s1_vc[p]];
    assign w_s1_tail[p] = tail_in[p][w_s1_vc[p]];
    assign w_nxt_vc[p]  = (w_s1_vc[p] == VCW'(VC_NUM-1)) ? '0 : w_s1_vc[p] + VCW'(1);
    assign w_in_won[p]  = |w_grant[p];
  end

  for (genvar o = 0; o < PORT_CNT; o++) begin : g_out
    logic [PORT_CNT-1:0] w_req;
    logic                w_rr_vld;
    logic [IPW-1:0]      w_rr_ip;

    always_comb begin
      w_req = '0;
      for (int p = 0; p < PORT_CNT; p++)
        w_req[p] = w_s1_vld[p] && (w_s1_op[p] == OPW'(o));
    end

    wsa_rr_pick #(.N(PORT_CNT), .W(IPW)) u_ip_rr (
      .i_req (w_req),
      .i_ptr (r_ip_ptr[o]),
      .o_vld (w_rr_vld),
      .o_idx (w_rr_ip)
    );

    // A locked output serves only its owner's packet, and only when the
    // owner's stage-1 pick is the owning VC; otherwise it idles.
    assign w_gnt_vld[o]  = r_lock[o] ? (w_req[r_own_p[o]] &&
                                        (w_s1_vc[r_own_p[o]] == r_own_v[o]))
                                     : w_rr_vld;
    assign w_gnt_ip[o]   = r_lock[o] ? r_own_p[o] : w_rr_ip;
    assign w_gnt_vc[o]   = w_s1_vc[w_gnt_ip[o]];
    assign w_gnt_tail[o] = w_s1_tail[w_gnt_ip[o]];
    assign w_nxt_ip[o]   = (w_rr_ip == IPW'(PORT_CNT-1)) ? '0 : w_rr_ip + IPW'(1);
  end

  // Each input bids for exactly one output, so at most one bit per input.
  always_comb begin
    w_grant = '0;
    for (int o = 0; o < PORT_CNT; o++)
      if (w_gnt_vld[o]) w_grant[w_gnt_ip[o]][w_gnt_vc[o]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vc_ptr <= '0;
      r_ip_ptr <= '0;
      r_lock   <= '0;
      r_own_p  <= '0;
      r_own_v  <= '0;
      r_grant  <= '0;
      r_xv     <= '0;
      r_xs     <= '0;
    end else begin
      r_grant <= w_grant;
      r_xv    <= w_gnt_vld;
      for (int o = 0; o < PORT_CNT; o++) begin
        r_xs[o] <= w_gnt_vld[o] ? w_gnt_ip[o] : '0;
        if (w_gnt_vld[o]) begin
          // body flits of a locked packet do not rotate the input pointer
          if (!r_lock[o]) r_ip_ptr[o] <= w_nxt_ip[o];
          r_lock[o]  <= !w_gnt_tail[o];
          r_own_p[o] <= w_gnt_ip[o];
          r_own_v[o] <= w_gnt_vc[o];
        end
      end
      for (int p = 0; p < PORT_CNT; p++)
        if (w_in_won[p]) r_vc_ptr[p] <= w_nxt_vc[p];
    end
  end

  assign grant_o      = r_grant;
  assign xbar_valid_o = r_xv;
  assign xbar_sel_o   = r_xs;

endmodule

// File: tb/tb_wormhole_switch_allocator.sv
// Scoreboard bench for wormhole_switch_allocator: a packet-level reference
// model predicts each cycle's grants; a monitor compares them one cycle later.
module tb_wormhole_switch_allocator;
  localparam int P = 5, V = 4, OPW = 3, IPW = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [P-1:0][V-1:0]          request_in, tail_in, grant_o;
  logic [P-1:0][V-1:0][OPW-1:0] out_port_in;
  logic [P-1:0]                 out_ready_in, xbar_valid_o;
  logic [P-1:0][IPW-1:0]        xbar_sel_o;

  always #5 clk = ~clk;

  wormhole_switch_allocator #(.PORT_CNT(P), .VC_NUM(V)) dut (
    .clk(clk), .rst_n(rst_n), .request_in(request_in), .out_port_in(out_port_in),
    .tail_in(tail_in), .out_ready_in(out_ready_in), .grant_o(grant_o),
    .xbar_valid_o(xbar_valid_o), .xbar_sel_o(xbar_sel_o)
  );

  typedef struct packed {
    logic [P-1:0][V-1:0]   g;
    logic [P-1:0]          xv;
    logic [P-1:0][IPW-1:0] xs;
    logic [P-1:0]          wt;   // input's pick targets a free output
    logic [P-1:0][OPW-1:0] wo;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_fail = 0;

  // reference model state
  int m_vcp[P], m_ipp[P], m_own_p[P], m_own_v[P];
  bit m_lock[P];
  // random traffic state per VC
  bit act[P][V];
  int rem[P][V], port[P][V];
  int stv[P];

  task automatic chk(input string nm, input longint a, input longint e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    request_in = '0; out_port_in = '0; tail_in = '0; out_ready_in = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < P; i++) begin
      m_vcp[i] = 0; m_ipp[i] = 0; m_lock[i] = 0; m_own_p[i] = 0; m_own_v[i] = 0;
      for (int v = 0; v < V; v++) act[i][v] = 0;
    end
  endtask

  // One arbitration on the currently driven inputs.
  task automatic model_step(output exp_t e);
    int win[P], gi[P];
    int o, v, c;
    e = '0;
    for (int p = 0; p < P; p++) begin
      win[p] = -1;
      for (int k = 0; k < V; k++) begin
        v = (m_vcp[p] + k) % V;
        o = int'(out_port_in[p][v]);
        if (win[p] < 0 && request_in[p][v] && o < P && out_ready_in[o] &&
            (!m_lock[o] || (m_own_p[o] == p && m_own_v[o] == v)))
          win[p] = v;
      end
    end
    for (int oo = 0; oo < P; oo++) begin
      gi[oo] = -1;
      if (m_lock[oo]) begin
        if (win[m_own_p[oo]] == m_own_v[oo] &&
            int'(out_port_in[m_own_p[oo]][m_own_v[oo]]) == oo)
          gi[oo] = m_own_p[oo];
      end else begin
        for (int k = 0; k < P; k++) begin
          c = (m_ipp[oo] + k) % P;
          if (gi[oo] < 0 && win[c] >= 0 && int'(out_port_in[c][win[c]]) == oo) gi[oo] = c;
        end
      end
    end
    for (int p = 0; p < P; p++)
      if (win[p] >= 0) begin
        o = int'(out_port_in[p][win[p]]);
        e.wt[p] = !m_lock[o];
        e.wo[p] = OPW'(o);
      end
    for (int oo = 0; oo < P; oo++) begin
      if (gi[oo] >= 0) begin
        c = gi[oo]; v = win[c];
        e.g[c][v] = 1'b1; e.xv[oo] = 1'b1; e.xs[oo] = IPW'(c);
        m_vcp[c] = (v + 1) % V;
        if (!m_lock[oo]) m_ipp[oo] = (c + 1) % P;
        m_lock[oo] = !tail_in[c][v];
        m_own_p[oo] = c; m_own_v[oo] = v;
      end
    end
  endtask

  task automatic step(output exp_t e);
    model_step(e);
    q.push_back(e);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    clr();
    #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_xvalid", xbar_valid_o, 0);
    chk("rst_xsel", xbar_sel_o, 0);
    q.delete();
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic rnd_drive();
    for (int p = 0; p < P; p++)
      for (int v = 0; v < V; v++) begin
        if (!act[p][v]) begin
          if ($urandom_range(3) == 0) begin
            act[p][v] = 1;
            if ($urandom_range(15) == 0) begin
              port[p][v] = 5 + $urandom_range(2); rem[p][v] = 1;
            end else begin
              port[p][v] = $urandom_range(P-1); rem[p][v] = 1 + $urandom_range(2);
            end
          end
        end else if (port[p][v] >= P && $urandom_range(2) == 0) act[p][v] = 0;
        request_in[p][v]  = act[p][v];
        out_port_in[p][v] = OPW'(port[p][v]);
        tail_in[p][v]     = (rem[p][v] == 1);
      end
    for (int o = 0; o < P; o++) out_ready_in[o] = ($urandom_range(4) != 0);
  endtask

  // monitor: pops the expectation for the arbitration registered at this edge
  initial begin
    exp_t e;
    bit have;
    logic [P-1:0] seen;
    bit dup;
    for (int i = 0; i < P; i++) stv[i] = 0;
    forever begin
      @(posedge clk);
      have = 0;
      if (rst_n && q.size() > 0) begin e = q.pop_front(); have = 1; end
      #2;
      if (!rst_n) for (int i = 0; i < P; i++) stv[i] = 0;
      if (have && rst_n) begin
        chk("grant", grant_o, e.g);
        chk("xbar_valid", xbar_valid_o, e.xv);
        chk("xbar_sel", xbar_sel_o, e.xs);
        seen = '0; dup = 0;
        for (int o = 0; o < P; o++)
          if (xbar_valid_o[o]) begin
            if (seen[xbar_sel_o[o]]) dup = 1;
            seen[xbar_sel_o[o]] = 1'b1;
          end
        chk("out_unique_input", dup, 0);
        chk("grant_count", $countones(grant_o), $countones(xbar_valid_o));
        for (int p = 0; p < P; p++) begin
          chk("in_onehot", ($countones(grant_o[p]) <= 1), 1);
          if (!e.wt[p] || grant_o[p] != '0) stv[p] = 0;
          else if (xbar_valid_o[e.wo[p]]) begin
            stv[p]++;
            chk("starvation", (stv[p] <= P*V), 1);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b1;
    clr();
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("init_grant", grant_o, 0);
    chk("init_xvalid", xbar_valid_o, 0);
    chk("init_xsel", xbar_sel_o, 0);
    repeat (2) tick();
    rst_n = 1'b1;

    // three inputs share output 4 with single-flit packets
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i > 0) begin
        chk("t2_sel", xbar_sel_o[4], i);
        chk("t2_vld", xbar_valid_o[4], 1);
      end
      if (i == 0) begin
        out_ready_in = '1;
        for (int p = 1; p <= 3; p++) begin
          request_in[p][0] = 1; out_port_in[p][0] = 3'd4; tail_in[p][0] = 1;
        end
      end
      if (i == 3) clr();
      step(e);
    end

    // wormhole lock on output 1 held by input 0 VC2
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i > 0) begin
        chk("t3_vld", xbar_valid_o[1], 1);
        chk("t3_sel", xbar_sel_o[1], (i <= 6) ? 0 : 3);
        chk("t3_g02", grant_o[0][2], (i <= 6) ? 1 : 0);
      end
      case (i)
        0: begin out_ready_in = '1; request_in[0][2] = 1; out_port_in[0][2] = 3'd1; tail_in[0][2] = 0; end
        1: begin request_in[3][0] = 1; out_port_in[3][0] = 3'd1; tail_in[3][0] = 1; end
        5: tail_in[0][2] = 1;
        6: request_in[0][2] = 0;
        7: clr();
        default: ;
      endcase
      step(e);
    end

    // one input, four VCs to distinct outputs: VC round-robin
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i > 0) chk("t4_grant2", grant_o[2], 1 << ((i-1) % 4));
      if (i == 0) begin
        out_ready_in = '1;
        for (int v = 0; v < V; v++) begin
          request_in[2][v] = 1; out_port_in[2][v] = OPW'(v); tail_in[2][v] = 1;
        end
      end
      if (i == 5) clr();
      step(e);
    end

    // downstream not ready masks output 3
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 1 || i == 2 || i == 5) chk("t5_idle", xbar_valid_o[3], 0);
      if (i == 3 || i == 4) begin
        chk("t5_vld", xbar_valid_o[3], 1);
        chk("t5_sel", xbar_sel_o[3], i - 3);
      end
      if (i == 0) begin
        out_ready_in = 5'b10111;
        for (int p = 0; p <= 1; p++) begin
          request_in[p][0] = 1; out_port_in[p][0] = 3'd3; tail_in[p][0] = 1;
        end
      end
      if (i == 2) out_ready_in[3] = 1'b1;
      if (i == 4) clr();
      step(e);
    end

    // random traffic with a reset in the middle
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc == 1000) do_reset();
      tick();
      rnd_drive();
      step(e);
      for (int p = 0; p < P; p++)
        for (int v = 0; v < V; v++)
          if (e.g[p][v]) begin
            rem[p][v]--;
            if (rem[p][v] <= 0) act[p][v] = 0;
          end
    end
    tick();
    clr();
    step(e);
    tick();
    tick();
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
